// File: rtl/mn_symbol_packer.sv
// Packs qualified {m,n} symbols four-per-byte (first symbol in the MSBs) and
// detects the symbol sequence 11 -> 10 -> 01 with a saturating detection count.
module mn_symbol_packer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             m,
    input  logic             n,
    input  logic             clr,
    output logic [7:0]       word,
    output logic             word_vld,
    output logic             det,
    output logic [CNT_W-1:0] det_cnt
);

    // One-cold detector encoding; any other code is treated as illegal.
    typedef enum logic [2:0] {
        D0 = 3'b011,
        D1 = 3'b101,
        D2 = 3'b110
    } det_state_t;

    det_state_t       state_r;
    det_state_t       state_nxt_s;
    logic             hit_s;
    logic [1:0]       sym_s;
    logic [1:0]       slot_r;
    logic [7:0]       buf_r;
    logic [7:0]       buf_nxt_s;
    logic             cnt_sat_s;

    assign sym_s     = {m, n};
    assign cnt_sat_s = (det_cnt == {CNT_W{1'b1}});

    // Detector next state and match flag for the current symbol.
    always_comb begin
        state_nxt_s = D0;
        hit_s       = 1'b0;
        case (state_r)
            D0: begin
                if (sym_s == 2'b11) begin
                    state_nxt_s = D1;
                end else begin
                    state_nxt_s = D0;
                end
            end
            D1: begin
                if (sym_s == 2'b10) begin
                    state_nxt_s = D2;
                end else if (sym_s == 2'b11) begin
                    state_nxt_s = D1;
                end else begin
                    state_nxt_s = D0;
                end
            end
            D2: begin
                if (sym_s == 2'b01) begin
                    state_nxt_s = D0;
                    hit_s       = 1'b1;
                end else if (sym_s == 2'b11) begin
                    state_nxt_s = D1;
                end else begin
                    state_nxt_s = D0;
                end
            end
            default: begin
                state_nxt_s = D0;
                hit_s       = 1'b0;
            end
        endcase
    end

    // Shift buffer with the current symbol dropped into its slot position.
    always_comb begin
        buf_nxt_s = buf_r;
        case (slot_r)
            2'd0:    buf_nxt_s[7:6] = sym_s;
            2'd1:    buf_nxt_s[5:4] = sym_s;
            2'd2:    buf_nxt_s[3:2] = sym_s;
            2'd3:    buf_nxt_s[1:0] = sym_s;
            default: buf_nxt_s      = buf_r;
        endcase
    end

    // Packer, detector and counter state; clr keeps the last completed word.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            slot_r   <= 2'd0;
            buf_r    <= 8'h00;
            state_r  <= D0;
            word     <= 8'h00;
            word_vld <= 1'b0;
            det      <= 1'b0;
            det_cnt  <= {CNT_W{1'b0}};
        end else if (clr) begin
            slot_r   <= 2'd0;
            buf_r    <= 8'h00;
            state_r  <= D0;
            word_vld <= 1'b0;
            det      <= 1'b0;
            det_cnt  <= {CNT_W{1'b0}};
        end else if (en) begin
            slot_r   <= slot_r + 2'd1;
            buf_r    <= buf_nxt_s;
            state_r  <= state_nxt_s;
            det      <= hit_s;
            word_vld <= (slot_r == 2'd3);
            if (slot_r == 2'd3) begin
                word <= buf_nxt_s;
            end
            if (hit_s && !cnt_sat_s) begin
                det_cnt <= det_cnt + CNT_W'(1);
            end
        end else begin
            word_vld <= 1'b0;
            det      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mn_symbol_packer.sv
// Directed plus random stimulus against a queue-based reference of the packer
// and the 11,10,01 sequence detector.
module tb_mn_symbol_packer;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             en;
    logic             m;
    logic             n;
    logic             clr;
    logic [7:0]       word;
    logic             word_vld;
    logic             det;
    logic [CNT_W-1:0] det_cnt;

    int total = 0;
    int bad   = 0;

    // Reference: accepted symbols since the last clear, as plain queues.
    logic [7:0] e_word;
    logic       e_vld;
    logic       e_det;
    int         e_cnt;
    logic [1:0] packq[$];
    logic [1:0] hist[$];

    mn_symbol_packer #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .en       (en),
        .m        (m),
        .n        (n),
        .clr      (clr),
        .word     (word),
        .word_vld (word_vld),
        .det      (det),
        .det_cnt  (det_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rb, input logic c, input logic e, input logic [1:0] s);
        if (!rb) begin
            e_word = 8'h00; e_vld = 1'b0; e_det = 1'b0; e_cnt = 0;
            packq.delete(); hist.delete();
        end else if (c) begin
            e_vld = 1'b0; e_det = 1'b0; e_cnt = 0;
            packq.delete(); hist.delete();
        end else if (e) begin
            e_vld = 1'b0; e_det = 1'b0;
            packq.push_back(s);
            hist.push_back(s);
            if (hist.size() > 3) void'(hist.pop_front());
            if (packq.size() == 4) begin
                e_word = {packq[0], packq[1], packq[2], packq[3]};
                e_vld  = 1'b1;
                packq.delete();
            end
            if (hist.size() == 3 && hist[0] == 2'b11 && hist[1] == 2'b10 && hist[2] == 2'b01) begin
                e_det = 1'b1;
                if (e_cnt < CNT_MAX) e_cnt++;
            end
        end else begin
            e_vld = 1'b0; e_det = 1'b0;
        end
    endtask

    task automatic step(input logic rb, input logic c, input logic e, input logic [1:0] s);
        rst_b = rb; clr = c; en = e; {m, n} = s;
        model(rb, c, e, s);
        @(posedge clk);
        #1;
        chk("word", word, e_word);
        chk("word_vld", word_vld, e_vld);
        chk("det", det, e_det);
        chk("det_cnt", det_cnt, e_cnt);
    endtask

    task automatic sym(input logic [1:0] s);
        step(1'b1, 1'b0, 1'b1, s);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 2'($urandom_range(3, 0)));
    endtask

    task automatic do_clr();
        step(1'b1, 1'b1, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)));
    endtask

    initial begin
        int sat_exp [5] = '{1, 2, 3, 3, 3};
        rst_b = 1'b0; clr = 1'b0; en = 1'b0; m = 1'b0; n = 1'b0;
        e_word = 8'h00; e_vld = 1'b0; e_det = 1'b0; e_cnt = 0;
        #1;

        // Reset with random inputs, then idle
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)));
        chk("rst_word", word, 8'h00);
        chk("rst_cnt", det_cnt, 0);
        for (int i = 0; i < 5; i++) idle();
        chk("idle_word", word, 8'h00);

        // Pack + detect
        sym(2'b11); sym(2'b10); sym(2'b01);
        chk("pk_det", det, 1);
        chk("pk_cnt", det_cnt, 1);
        sym(2'b00);
        chk("pk_word", word, 8'hE4);
        chk("pk_vld", word_vld, 1);
        chk("pk_det_off", det, 0);
        idle();
        chk("pk_vld_off", word_vld, 0);

        // Restart / overlap
        sym(2'b11); sym(2'b11); sym(2'b10);
        chk("rs_no_det", det, 0);
        sym(2'b01);
        chk("rs_det", det, 1);
        sym(2'b11); sym(2'b10); sym(2'b11); sym(2'b10);
        chk("ov_no_det", det, 0);
        sym(2'b01);
        chk("ov_det", det, 1);

        // Gaps between accepted symbols
        do_clr();
        sym(2'b00); for (int i = 0; i < 3; i++) idle();
        sym(2'b01); for (int i = 0; i < 3; i++) idle();
        sym(2'b10); for (int i = 0; i < 3; i++) idle();
        sym(2'b11);
        chk("gap_word", word, 8'h1B);
        chk("gap_vld", word_vld, 1);
        idle();
        chk("gap_vld_off", word_vld, 0);

        // Saturation of the 2-bit counter
        do_clr();
        for (int k = 0; k < 5; k++) begin
            sym(2'b11); sym(2'b10); sym(2'b01);
            chk("sat_det", det, 1);
            chk("sat_cnt", det_cnt, sat_exp[k]);
        end

        // clr mid-word drops the partial word and the same-cycle symbol
        do_clr();
        sym(2'b10); sym(2'b10);
        step(1'b1, 1'b1, 1'b1, 2'b11);
        for (int i = 0; i < 4; i++) sym(2'b01);
        chk("clr_word", word, 8'h55);
        sym(2'b11); sym(2'b10); sym(2'b01);
        do_clr();
        chk("clr_cnt", det_cnt, 0);
        chk("clr_keep_word", word, 8'h55);
        sym(2'b01); sym(2'b01);
        step(1'b0, 1'b0, 1'b1, 2'b01);
        chk("rst_mid_word", word, 8'h00);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(59, 0) != 0), 1'($urandom_range(29, 0) == 0),
                 1'($urandom_range(3, 0) != 0), 2'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mn_symbol_packer.md
Name: mn_symbol_packer

Overview:
Downstream consumer of the (m, n) output pair produced by the mode-control FSM. Treats {m,n} as a 2-bit symbol sampled on qualified cycles. Packs every 4 symbols into a byte for the bus side. In parallel, a one-cold Mealy-style detector flags the symbol sequence 11 -> 10 -> 01 and keeps a saturating count of detections.

Parameters:
CNT_W, 8, width of the saturating detection counter det_cnt.

Ports:
clk  input  1  system clock, rising edge.
rst_b  input  1  reset, synchronous, active-low.
en  input  1  symbol qualifier; {m,n} is accepted on a rising edge with en=1.
m  input  1  symbol MSB, from the upstream FSM output m.
n  input  1  symbol LSB, from the upstream FSM output n.
clr  input  1  synchronous soft clear of the packer, detector and counter.
word  output  8  last completed packed byte; first symbol in word[7:6].
word_vld  output  1  one-cycle pulse: word has just been updated.
det  output  1  one-cycle pulse: sequence 11,10,01 completed.
det_cnt  output  CNT_W  saturating number of detections.

Behaviour:
- One clock domain. rst_b is synchronous and active-low; reset acts only on a clk rising edge.
- All outputs are registered. Nothing is combinational from the inputs.
- Reset (rst_b=0 at an edge):
  - word=8'h00, word_vld=0, det=0, det_cnt=0.
  - Slot counter=0, FSM=D0.
  - Takes priority over clr and en. A partial word in flight is discarded.
- Symbol s={m,n}. It is accepted only at an edge with rst_b=1, clr=0 and en=1.
- Packer:
  - 2-bit slot counter 0..3. Accepted symbol goes to the shift buffer at slot position: slot0->[7:6], slot1->[5:4], slot2->[3:2], slot3->[1:0].
  - The slot counter increments on each accepted symbol and wraps 3->0.
  - When the slot-3 symbol is accepted, word loads the full byte at that edge and word_vld=1 for exactly that following cycle.
  - word holds its value until the next completion.
  - With 4 consecutive accepted symbols, latency from the slot-3 acceptance edge to word_vld visible is 0 cycles, i.e. the same edge.
- Detector FSM, one-cold 3-bit state: D0=3'b011, D1=3'b101, D2=3'b110.
  - D0: s=11 -> D1; else stay D0.
  - D1: s=10 -> D2; s=11 -> D1; else D0.
  - D2: s=01 -> D0 and det=1 next cycle; s=11 -> D1; else D0.
  - Any other state code (not one-cold) -> D0 on the next edge. det is not asserted from an illegal state.
  - A detection does not overlap into a new match except via a fresh 11.
- det_cnt:
  - Increments by 1 at the same edge det is set.
  - Saturates at 2^CNT_W-1 with no wrap; det still pulses at saturation.
- en=0 at an edge:
  - FSM, slot counter, buffer, word and det_cnt all hold.
  - word_vld=0 and det=0 (pulses never stretch).
- clr=1 at an edge (rst_b=1):
  - Slot counter=0, buffer discarded, FSM=D0, det_cnt=0, word_vld=0, det=0.
  - word retains its last value.
  - A symbol presented in the same cycle is dropped (clr beats en).
- Pulses: word_vld and det may be high in the same cycle.

Test Plan:
- Reset: drive rst_b=0 for 2 edges with random m/n/en -> word=8'h00, word_vld=0, det=0, det_cnt=0. Release, hold en=0 for 5 cycles -> outputs unchanged.
- Pack+detect: en=1, symbols 11,10,01,00 on consecutive edges -> det=1 in the cycle after the 3rd edge, det_cnt=1. After the 4th edge, word=8'hE4 and word_vld=1 for one cycle.
- Restart/overlap: symbols 11,11,10,01 -> exactly one det pulse after the 4th symbol. Symbols 11,10,11,10,01 -> one det pulse, after the 5th symbol.
- Gaps: symbols 00,01,10,11 with en=0 for 3 cycles between each -> word=8'h1B, word_vld exactly one cycle after the last accepted symbol, no spurious pulses during gaps.
- Saturation with CNT_W=2: repeat 11,10,01 five times -> five det pulses, det_cnt sequence 1,2,3,3,3.
- clr/reset mid-word: accept 10,10, then clr=1 with en=1 and s=11, then 01,01,01,01 -> word=8'h55, not containing 10. clr after a detection -> det_cnt=0. rst_b=0 mid-word -> word=8'h00.
